// File: rtl/mt_pkg.sv
// ============================================================================
// Module : mt_pkg
// Brief  : Shared types and constants for the Mersenne-Twister state seeder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] F32          = 32'h6C078965;
    localparam logic [63:0] F64          = 64'h5851F42D4C957F2D;
    localparam int          N32          = 624;
    localparam int          N64          = 312;
    localparam logic [31:0] DEFAULT_SEED = 32'd5489;

    // Right-shift applied to s_i before the multiply (30 for W=32, 62 for W=64).
    function automatic int shift_amt(input int w);
        return w - 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mt_seed_gen_if.sv
// ============================================================================
// Module : mt_seed_gen_if
// Brief  : Control handshake and state-RAM write port of the MT seeder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mt_seed_gen_if #(
    parameter int W      = 32,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [W-1:0]      seed_value;
    logic              abort;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;

    // master: the seeder itself; slave: the controlling FSM plus state RAM.
    modport master (
        input  start, seed_value, abort, wr_ready,
        output busy, done, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, seed_value, abort, wr_ready,
        input  busy, done, wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/mt_seed_step.sv
// ============================================================================
// Module : mt_seed_step
// Brief  : Next-word datapath s_{i+1} = F*(s_i ^ (s_i >> (W-2))) + (i+1).
//          Product and final add are exposed separately so a register can
//          be placed between them.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mt_seed_step
    import mt_pkg::*;
#(
    parameter int           W = 32,
    parameter logic [W-1:0] F = W'((W == 64) ? F64 : 64'(F32))
) (
    input  wire logic [W-1:0] s_cur,
    input  wire logic [W-1:0] prod_base,
    input  wire logic [W-1:0] idx,
    output logic      [W-1:0] prod,
    output logic      [W-1:0] next_word
);
    localparam int SH = shift_amt(W);

    logic [W-1:0] w_mixed;

    assign w_mixed   = s_cur ^ (s_cur >> SH);
    assign prod      = F * w_mixed;
    assign next_word = prod_base + idx;

endmodule

`default_nettype wire

// File: rtl/mt_seed_gen.sv
// ============================================================================
// Module : mt_seed_gen
// Brief  : Mersenne-Twister state initialiser writing N seeded words into
//          the state RAM. Define MT_SEED_MULT_PIPE_EN to register the
//          product (one word per two cycles).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mt_seed_gen
    import mt_pkg::*;
#(
    parameter int           W      = 32,
    parameter int           N      = (W == 64) ? N64 : N32,
    parameter logic [W-1:0] F      = W'((W == 64) ? F64 : 64'(F32)),
    parameter int           ADDR_W = 10
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mt_seed_gen_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [W-1:0]      r_s;
    logic [W-1:0]      w_s_nx;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nx;
    logic              r_valid;
    logic              w_valid_nx;

    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_idx_inc;
    logic [W-1:0]      w_prod;
    logic [W-1:0]      w_next_word;
    logic [W-1:0]      w_prod_base;
    logic [W-1:0]      w_step_idx;

`ifdef MT_SEED_MULT_PIPE_EN
    logic              r_pend;
    logic              w_pend_nx;
    logic [W-1:0]      r_prod;
    logic [W-1:0]      w_prod_nx;

    // r_idx already holds i+1 while the registered product waits.
    assign w_prod_base = r_prod;
    assign w_step_idx  = W'(r_idx);
`else
    assign w_prod_base = w_prod;
    assign w_step_idx  = W'(w_idx_inc);
`endif

    mt_seed_step #(
        .W (W),
        .F (F)
    ) u_step (
        .s_cur     (r_s),
        .prod_base (w_prod_base),
        .idx       (w_step_idx),
        .prod      (w_prod),
        .next_word (w_next_word)
    );

    assign w_accept  = r_valid && bus.wr_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_idx_inc = r_idx + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
`ifdef MT_SEED_MULT_PIPE_EN
            r_pend  <= 1'b0;
            r_prod  <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_idx   <= w_idx_nx;
            r_valid <= w_valid_nx;
`ifdef MT_SEED_MULT_PIPE_EN
            r_pend  <= w_pend_nx;
            r_prod  <= w_prod_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_idx_nx   = r_idx;
        w_valid_nx = r_valid;
`ifdef MT_SEED_MULT_PIPE_EN
        w_pend_nx  = r_pend;
        w_prod_nx  = r_prod;
`endif
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nx = RUN;
                    w_s_nx     = bus.seed_value;
                    w_idx_nx   = '0;
                    w_valid_nx = 1'b1;
`ifdef MT_SEED_MULT_PIPE_EN
                    w_pend_nx  = 1'b0;
`endif
                end
            end
            RUN: begin
                // Abort takes priority, even over acceptance of the last word.
                if (bus.abort) begin
                    w_state_nx = IDLE;
                    w_valid_nx = 1'b0;
`ifdef MT_SEED_MULT_PIPE_EN
                    w_pend_nx  = 1'b0;
`endif
                end else if (w_accept) begin
                    if (w_last) begin
                        w_state_nx = DONE;
                        w_valid_nx = 1'b0;
                    end else begin
                        w_idx_nx   = w_idx_inc;
`ifdef MT_SEED_MULT_PIPE_EN
                        w_valid_nx = 1'b0;
                        w_pend_nx  = 1'b1;
                        w_prod_nx  = w_prod;
`else
                        w_s_nx     = w_next_word;
                        w_valid_nx = 1'b1;
`endif
                    end
                end
`ifdef MT_SEED_MULT_PIPE_EN
                else if (r_pend) begin
                    w_s_nx     = w_next_word;
                    w_valid_nx = 1'b1;
                    w_pend_nx  = 1'b0;
                end
`endif
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.wr_en   = r_valid;
    assign bus.wr_addr = r_idx;
    assign bus.wr_data = r_s;

endmodule

`default_nettype wire

// File: tb/tb_mt_seed_gen.sv
// ============================================================================
// Module : tb_mt_seed_gen
// Brief  : Scoreboard bench for mt_seed_gen (W=32 and W=64 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mt_seed_gen;
    import mt_pkg::*;

`ifdef MT_SEED_MULT_PIPE_EN
    localparam int SP = 2;
`else
    localparam int SP = 1;
`endif

    typedef struct {
        int unsigned addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rnd_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mt_seed_gen_if #(.W(32), .ADDR_W(10)) b32 ();
    mt_seed_gen_if #(.W(64), .ADDR_W(9))  b64 ();

    mt_seed_gen #(.W(32), .N(624), .F(F32), .ADDR_W(10)) u32 (.clk(clk), .rst(rst), .bus(b32));
    mt_seed_gen #(.W(64), .N(312), .F(F64), .ADDR_W(9))  u64 (.clk(clk), .rst(rst), .bus(b64));

    exp_t        q32[$];
    exp_t        q64[$];
    logic [31:0] mem32 [1024];
    logic [31:0] ref32 [1024];
    logic [63:0] mem64 [512];
    int          acc32 [1024];
    int          acc64 [512];
    int          done_cnt32 = 0, done_cyc32 = 0;
    int          done_cnt64 = 0, done_cyc64 = 0;
    logic        p_stall32 = 1'b0;
    logic [9:0]  p_addr32 = '0;
    logic [31:0] p_data32 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] nx32(input logic [31:0] s, input int i);
        logic [31:0] m;
        m = s ^ (s >> 30);
        return F32 * m + 32'(i);
    endfunction

    function automatic logic [63:0] nx64(input logic [63:0] s, input int i);
        logic [63:0] m;
        m = s ^ (s >> 62);
        return F64 * m + 64'(i);
    endfunction

    task automatic push32(input logic [31:0] seed, input int count);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i < count; i++) begin
            if (i > 0) s = nx32(s, i);
            q32.push_back('{addr: i, data: 64'(s)});
        end
    endtask

    task automatic push64(input logic [63:0] seed, input int count);
        logic [63:0] s;
        s = seed;
        for (int i = 0; i < count; i++) begin
            if (i > 0) s = nx64(s, i);
            q64.push_back('{addr: i, data: s});
        end
    endtask

    // Scoreboard monitor, W=32: pop on every accepted word, check stall holds.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (p_stall32)
                chk("stall_hold32", 64'({b32.wr_en, b32.wr_addr, b32.wr_data}),
                    64'({1'b1, p_addr32, p_data32}));
            if (b32.wr_en && b32.wr_ready) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write32: got addr %0d, expected no write", b32.wr_addr);
                end else begin
                    e = q32.pop_front();
                    chk("addr32", 64'(b32.wr_addr), 64'(e.addr));
                    chk("data32", 64'(b32.wr_data), e.data);
                end
                mem32[b32.wr_addr] = b32.wr_data;
                acc32[b32.wr_addr] = cyc;
            end
            if (b32.done) begin
                done_cnt32++;
                done_cyc32 = cyc;
            end
        end
        p_stall32 = !rst && b32.wr_en && !b32.wr_ready && !b32.abort;
        p_addr32  = b32.wr_addr;
        p_data32  = b32.wr_data;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b64.wr_en && b64.wr_ready) begin
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write64: got addr %0d, expected no write", b64.wr_addr);
                end else begin
                    e = q64.pop_front();
                    chk("addr64", 64'(b64.wr_addr), 64'(e.addr));
                    chk("data64", b64.wr_data, e.data);
                end
                mem64[b64.wr_addr] = b64.wr_data;
                acc64[b64.wr_addr] = cyc;
            end
            if (b64.done) begin
                done_cnt64++;
                done_cyc64 = cyc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        b32.wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        b64.wr_ready = 1'b1;
    end

    task automatic start32(input logic [31:0] seed);
        @(posedge clk); #1;
        b32.seed_value = seed;
        b32.start      = 1'b1;
        @(posedge clk); #1;
        b32.start      = 1'b0;
        b32.seed_value = 32'hA5A5_5A5A;
        @(negedge clk);
        chk("first_wen32",  64'(b32.wr_en),   64'd1);
        chk("first_addr32", 64'(b32.wr_addr), 64'd0);
        chk("first_busy32", 64'(b32.busy),    64'd1);
    endtask

    task automatic start64(input logic [63:0] seed);
        @(posedge clk); #1;
        b64.seed_value = seed;
        b64.start      = 1'b1;
        @(posedge clk); #1;
        b64.start      = 1'b0;
        b64.seed_value = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        chk("first_wen64",  64'(b64.wr_en),   64'd1);
        chk("first_addr64", 64'(b64.wr_addr), 64'd0);
    endtask

    task automatic wait_done32(input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = b32.done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout32: got no done, expected done within %0d cycles", budget);
        end
        @(negedge clk);
        chk("after_done32", 64'({b32.busy, b32.done}), 64'd0);
    endtask

    task automatic wait_done64(input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = b64.done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout64: got no done, expected done within %0d cycles", budget);
        end
        @(negedge clk);
        chk("after_done64", 64'({b64.busy, b64.done}), 64'd0);
    endtask

    task automatic wait_addr32(input int a, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = b32.wr_en && (int'(b32.wr_addr) == a);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL addr_timeout32: got no presentation, expected addr %0d", a);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int diffs;
        b32.start = 1'b0; b32.abort = 1'b0; b32.seed_value = '0;
        b64.start = 1'b0; b64.abort = 1'b0; b64.seed_value = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out32", 64'({b32.busy, b32.done, b32.wr_en, b32.wr_addr, b32.wr_data}), 64'd0);
        chk("rst_out64", {b64.busy, b64.done, b64.wr_en}, 64'd0);
        chk("rst_data64", b64.wr_data | 64'(b64.wr_addr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // W=32, seed 0, continuous ready
        push32(32'd0, 624);
        dc = done_cnt32;
        start32(32'd0);
        wait_done32(4000);
        chk("q_empty_seed0",  64'(q32.size()), 64'd0);
        chk("seed0_word1",    64'(mem32[1]), 64'd1);
        chk("seed0_word2",    64'(mem32[2]), 64'd1812433255);
        chk("spacing32",      64'(acc32[623] - acc32[0]), 64'(623 * SP));
        chk("done_latency32", 64'(done_cyc32 - acc32[623]), 64'd1);
        chk("done_count32",   64'(done_cnt32 - dc), 64'd1);

        // W=32, default seed 5489
        push32(DEFAULT_SEED, 624);
        dc = done_cnt32;
        start32(DEFAULT_SEED);
        wait_done32(4000);
        chk("q_empty_5489",  64'(q32.size()), 64'd0);
        chk("seed5489_word1", 64'(mem32[1]), 64'h4D98EE96);
        chk("done_count5489", 64'(done_cnt32 - dc), 64'd1);
        for (int i = 0; i < 624; i++) ref32[i] = mem32[i];

        // W=64, seed 0
        push64(64'd0, 312);
        dc = done_cnt64;
        start64(64'd0);
        wait_done64(4000);
        chk("q_empty64",   64'(q64.size()), 64'd0);
        chk("w64_word1",   mem64[1], 64'd1);
        chk("w64_word2",   mem64[2], 64'h5851F42D4C957F2F);
        chk("spacing64",   64'(acc64[311] - acc64[0]), 64'(311 * SP));
        chk("done_count64", 64'(done_cnt64 - dc), 64'd1);

        // W=32, seed 5489 with random back-pressure
        for (int i = 0; i < 1024; i++) mem32[i] = 32'hDEAD_BEEF;
        rnd_ready = 1'b1;
        push32(DEFAULT_SEED, 624);
        dc = done_cnt32;
        start32(DEFAULT_SEED);
        wait_done32(8000);
        rnd_ready = 1'b0;
        diffs = 0;
        for (int i = 0; i < 624; i++) if (mem32[i] !== ref32[i]) diffs++;
        chk("stalled_image",    64'(diffs), 64'd0);
        chk("q_empty_stalled",  64'(q32.size()), 64'd0);
        chk("done_count_stall", 64'(done_cnt32 - dc), 64'd1);

        // abort while word 100 is accepted
        push32(32'd0, 101);
        dc = done_cnt32;
        start32(32'd0);
        wait_addr32(100, 1000);
        b32.abort = 1'b1;
        @(posedge clk); #1;
        b32.abort = 1'b0;
        @(negedge clk);
        chk("abort_out", 64'({b32.wr_en, b32.busy, b32.done}), 64'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt32 - dc), 64'd0);
        chk("q_empty_abort", 64'(q32.size()), 64'd0);

        // clean restart after abort
        push32(32'd0, 624);
        dc = done_cnt32;
        start32(32'd0);
        wait_done32(4000);
        chk("q_empty_restart",  64'(q32.size()), 64'd0);
        chk("done_count_restart", 64'(done_cnt32 - dc), 64'd1);

        // abort coincident with acceptance of the final word
        push32(32'd1, 624);
        dc = done_cnt32;
        start32(32'd1);
        wait_addr32(623, 4000);
        b32.abort = 1'b1;
        @(posedge clk); #1;
        b32.abort = 1'b0;
        @(negedge clk);
        chk("abort_last_out", 64'({b32.wr_en, b32.busy, b32.done}), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_last_no_done", 64'(done_cnt32 - dc), 64'd0);
        chk("q_empty_abort_last", 64'(q32.size()), 64'd0);

        // start and seed change mid-run are ignored; reset near address 300
        push32(32'd7, 300);
        dc = done_cnt32;
        start32(32'd7);
        wait_addr32(50, 1000);
        b32.start      = 1'b1;
        b32.seed_value = 32'h1234_5678;
        @(posedge clk); #1;
        b32.start      = 1'b0;
        wait_addr32(299, 1000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrun_rst_out", 64'({b32.busy, b32.done, b32.wr_en, b32.wr_addr, b32.wr_data}), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_no_done", 64'(done_cnt32 - dc), 64'd0);
        chk("q_empty_midrun", 64'(q32.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
